// File: rtl/io_arb_pkg.sv
// Shared types and helpers for the two-master io_bus arbiter.
// Tag layout is {mode[1:0], lock/unlock}; only AMO mode affects ownership.
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } arb_state_e;

    typedef logic mst_idx_t;

    localparam mst_idx_t MST0 = 1'b0;
    localparam mst_idx_t MST1 = 1'b1;

    localparam int unsigned ADDR_TAG_W       = 3;
    localparam logic [1:0]  ADDR_TAG_MODE_AMO = 2'b10;
    localparam logic        ADDR_TAG_LOCK     = 1'b1;
    localparam logic        ADDR_TAG_UNLOCK   = 1'b0;

    function automatic logic is_amo_lock(input logic [ADDR_TAG_W-1:0] tag, input logic we);
        return (tag[2:1] == ADDR_TAG_MODE_AMO) && (tag[0] == ADDR_TAG_LOCK) && !we;
    endfunction

    function automatic logic is_amo_unlock(input logic [ADDR_TAG_W-1:0] tag, input logic we);
        return (tag[2:1] == ADDR_TAG_MODE_AMO) && (tag[0] == ADDR_TAG_UNLOCK) && we;
    endfunction

endpackage

// File: rtl/io_arb_watchdog.sv
// Saturating cycle counter; expire_o flags the LIMIT-th consecutive inc cycle.
// Latency: expire_o is combinational from inc_i and the registered count.
// Backpressure: none; clr_i has priority over inc_i.
module io_arb_watchdog #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int unsigned CW = $clog2(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire_o = inc_i && !clr_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin Wishbone arbiter sharing the io_bus slave between M0 and M1.
// Latency: 1-cycle grant from IDLE; request/response paths are combinational while owned.
// Backpressure: non-owner simply waits with cyc/stb high; stalls are cut by the watchdog.
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned AMO_HOLD_MAX   = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [2:0]  m0_addr_tag_i,
    input  logic [31:0] m0_data_i,
    input  logic [3:0]  m0_sel_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_data_tag_o,
    output logic [31:0] m0_data_o,

    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [2:0]  m1_addr_tag_i,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m1_sel_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_data_tag_o,
    output logic [31:0] m1_data_o,

    output logic        s_stb_o,
    output logic        s_cyc_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [2:0]  s_addr_tag_o,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_sel_o,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_data_tag_i,
    input  logic [31:0] s_data_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    arb_state_e state_q, state_d;
    mst_idx_t   last_grant_q, last_grant_d;
    logic       amo_held_q, amo_held_d;
    logic       timeout_q, timeout_d;

    logic       own0, own1, owning, aborting;
    logic       own_cyc;
    mst_idx_t   own_idx;
    logic       m0_req, m1_req;
    logic       amo_set, amo_clr;
    logic       wd_inc, wd_expire;
    logic       hold_inc, hold_clr, hold_expire;

    assign own0     = (state_q == OWN0);
    assign own1     = (state_q == OWN1);
    assign owning   = own0 | own1;
    assign aborting = (state_q == ABORT);
    assign own_idx  = own1 ? MST1 : MST0;
    assign own_cyc  = own0 ? m0_cyc_i : (own1 ? m1_cyc_i : 1'b0);
    assign m0_req   = m0_cyc_i & m0_stb_i;
    assign m1_req   = m1_cyc_i & m1_stb_i;

    // stb is qualified by cyc so a mid-strobe cyc drop vanishes from the slave at once
    always_comb begin
        s_cyc_o      = 1'b0;
        s_stb_o      = 1'b0;
        s_we_o       = 1'b0;
        s_addr_o     = '0;
        s_addr_tag_o = '0;
        s_data_o     = '0;
        s_sel_o      = '0;
        if (own0) begin
            s_cyc_o      = m0_cyc_i;
            s_stb_o      = m0_cyc_i & m0_stb_i;
            s_we_o       = m0_we_i;
            s_addr_o     = m0_addr_i;
            s_addr_tag_o = m0_addr_tag_i;
            s_data_o     = m0_data_i;
            s_sel_o      = m0_sel_i;
        end else if (own1) begin
            s_cyc_o      = m1_cyc_i;
            s_stb_o      = m1_cyc_i & m1_stb_i;
            s_we_o       = m1_we_i;
            s_addr_o     = m1_addr_i;
            s_addr_tag_o = m1_addr_tag_i;
            s_data_o     = m1_data_i;
            s_sel_o      = m1_sel_i;
        end
    end

    // During ABORT last_grant_q already names the aborted owner
    assign m0_ack_o      = own0 & s_ack_i;
    assign m0_err_o      = (own0 & s_err_i) | (aborting & (last_grant_q == MST0));
    assign m0_data_tag_o = own0 & s_data_tag_i;
    assign m0_data_o     = own0 ? s_data_i : '0;
    assign m1_ack_o      = own1 & s_ack_i;
    assign m1_err_o      = (own1 & s_err_i) | (aborting & (last_grant_q == MST1));
    assign m1_data_tag_o = own1 & s_data_tag_i;
    assign m1_data_o     = own1 ? s_data_i : '0;

    assign grant_o   = {own1, own0};
    assign timeout_o = timeout_q;

    assign amo_set = owning & s_stb_o & s_ack_i & is_amo_lock(s_addr_tag_o, s_we_o);
    assign amo_clr = owning & s_stb_o & s_ack_i & is_amo_unlock(s_addr_tag_o, s_we_o);

    // A cycle carrying ack or err is never a stalled cycle, so ack beats expiry
    assign wd_inc   = s_stb_o & ~s_ack_i & ~s_err_i;
    assign hold_inc = owning & amo_held_q & ~own_cyc;
    assign hold_clr = ~owning | ~amo_held_q | s_stb_o;

    io_arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wd (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (wd_inc),
        .clr_i    (~wd_inc),
        .expire_o (wd_expire)
    );

    io_arb_watchdog #(
        .LIMIT (AMO_HOLD_MAX)
    ) u_hold (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (hold_inc),
        .clr_i    (hold_clr),
        .expire_o (hold_expire)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        amo_held_d   = amo_held_q;
        timeout_d    = 1'b0;
        if (amo_set) amo_held_d = 1'b1;
        if (amo_clr) amo_held_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = (last_grant_q == MST1) ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_d = OWN0;
                end else if (m1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (wd_expire) begin
                    state_d      = ABORT;
                    timeout_d    = 1'b1;
                    amo_held_d   = 1'b0;
                    last_grant_d = own_idx;
                end else if (hold_expire) begin
                    state_d      = IDLE;
                    timeout_d    = 1'b1;
                    amo_held_d   = 1'b0;
                    last_grant_d = own_idx;
                end else if (!own_cyc && !amo_held_q) begin
                    state_d      = IDLE;
                    last_grant_d = own_idx;
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= MST1;
            amo_held_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            amo_held_q   <= amo_held_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter with hand-computed expectations.
// Inputs change at the falling edge; outputs are sampled 1 ns later.
module tb_io_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_stb_i, m0_cyc_i, m0_we_i;
    logic [31:0] m0_addr_i, m0_data_i;
    logic [2:0]  m0_addr_tag_i;
    logic [3:0]  m0_sel_i;
    logic        m0_ack_o, m0_err_o, m0_data_tag_o;
    logic [31:0] m0_data_o;
    logic        m1_stb_i, m1_cyc_i, m1_we_i;
    logic [31:0] m1_addr_i, m1_data_i;
    logic [2:0]  m1_addr_tag_i;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o, m1_err_o, m1_data_tag_o;
    logic [31:0] m1_data_o;
    logic        s_stb_o, s_cyc_o, s_we_o;
    logic [31:0] s_addr_o, s_data_o;
    logic [2:0]  s_addr_tag_o;
    logic [3:0]  s_sel_o;
    logic        s_ack_i, s_err_i, s_data_tag_i;
    logic [31:0] s_data_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int vectors = 0;
    int errors  = 0;

    always #5 clk_i = ~clk_i;

    io_bus_arbiter #(
        .TIMEOUT_CYCLES (8),
        .AMO_HOLD_MAX   (6)
    ) dut (
        .clk_i (clk_i), .rst_i (rst_i),
        .m0_stb_i (m0_stb_i), .m0_cyc_i (m0_cyc_i), .m0_we_i (m0_we_i),
        .m0_addr_i (m0_addr_i), .m0_addr_tag_i (m0_addr_tag_i),
        .m0_data_i (m0_data_i), .m0_sel_i (m0_sel_i),
        .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
        .m0_data_tag_o (m0_data_tag_o), .m0_data_o (m0_data_o),
        .m1_stb_i (m1_stb_i), .m1_cyc_i (m1_cyc_i), .m1_we_i (m1_we_i),
        .m1_addr_i (m1_addr_i), .m1_addr_tag_i (m1_addr_tag_i),
        .m1_data_i (m1_data_i), .m1_sel_i (m1_sel_i),
        .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
        .m1_data_tag_o (m1_data_tag_o), .m1_data_o (m1_data_o),
        .s_stb_o (s_stb_o), .s_cyc_o (s_cyc_o), .s_we_o (s_we_o),
        .s_addr_o (s_addr_o), .s_addr_tag_o (s_addr_tag_o),
        .s_data_o (s_data_o), .s_sel_o (s_sel_o),
        .s_ack_i (s_ack_i), .s_err_i (s_err_i),
        .s_data_tag_i (s_data_tag_i), .s_data_i (s_data_i),
        .grant_o (grant_o), .timeout_o (timeout_o)
    );

    task automatic clear_inputs();
        m0_stb_i = 0; m0_cyc_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_addr_tag_i = '0; m0_data_i = '0; m0_sel_i = '0;
        m1_stb_i = 0; m1_cyc_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_addr_tag_i = '0; m1_data_i = '0; m1_sel_i = '0;
        s_ack_i = 0; s_err_i = 0; s_data_tag_i = 0; s_data_i = '0;
    endtask

    task automatic m0_request(input logic we, input logic [31:0] addr, input logic [2:0] tag);
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = we; m0_addr_i = addr; m0_addr_tag_i = tag; m0_sel_i = 4'hF;
    endtask

    task automatic m1_request(input logic we, input logic [31:0] addr, input logic [2:0] tag);
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = we; m1_addr_i = addr; m1_addr_tag_i = tag; m1_sel_i = 4'hF;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b1;
        #2 rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        vectors++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rst_grant got %b want 00", grant_o); end
        vectors++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("FAIL rst_s_cyc_stb got %b%b want 00", s_cyc_o, s_stb_o); end
        vectors++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", timeout_o); end
        vectors++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin errors++; $display("FAIL rst_resp got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
        @(negedge clk_i); rst_i = 1'b1;
        @(negedge clk_i); #1;
        vectors++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rst_release_grant got %b want 00", grant_o); end
    endtask

    task automatic test_single_read();
        @(negedge clk_i); m0_request(1'b0, 32'h8000_0004, 3'b000); #1;
        vectors++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rd_grant_latency got %b want 00", grant_o); end
        @(negedge clk_i); #1;
        vectors++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rd_grant got %b want 01", grant_o); end
        vectors++; if (s_cyc_o !== 1'b1 || s_addr_o !== 32'h8000_0004) begin errors++; $display("FAIL rd_s_addr got %b %h want 1 80000004", s_cyc_o, s_addr_o); end
        vectors++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL rd_early_ack got %b want 0", m0_ack_o); end
        @(negedge clk_i);
        @(negedge clk_i); s_ack_i = 1; s_data_i = 32'hDEAD_BEEF; #1;
        vectors++; if (m0_ack_o !== 1'b1 || m0_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_m0_resp got %b %h want 1 deadbeef", m0_ack_o, m0_data_o); end
        vectors++; if (m1_ack_o !== 1'b0 || m1_data_o !== 32'h0) begin errors++; $display("FAIL rd_m1_quiet got %b %h want 0 0", m1_ack_o, m1_data_o); end
        @(negedge clk_i); s_ack_i = 0; s_data_i = '0; m0_cyc_i = 0; m0_stb_i = 0; #1;
        vectors++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b01) begin errors++; $display("FAIL rd_cyc_drop got %b %b want 0 01", s_cyc_o, grant_o); end
        @(negedge clk_i); #1;
        vectors++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rd_release got %b want 00", grant_o); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i); rst_i = 0; clear_inputs();
        @(negedge clk_i); rst_i = 1;
        @(negedge clk_i); m0_request(1'b0, 32'h8000_0100, 3'b000); m1_request(1'b0, 32'h8000_0200, 3'b000);
        @(negedge clk_i); s_ack_i = 1; s_data_i = 32'h1111_0000; #1;
        vectors++; if (grant_o !== 2'b01 || s_addr_o !== 32'h8000_0100) begin errors++; $display("FAIL b2b_first got %b %h want 01 80000100", grant_o, s_addr_o); end
        vectors++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin errors++; $display("FAIL b2b_ack0 got %b%b want 10", m0_ack_o, m1_ack_o); end
        @(negedge clk_i); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; #1;
        vectors++; if (grant_o !== 2'b01) begin errors++; $display("FAIL b2b_hold got %b want 01", grant_o); end
        @(negedge clk_i); #1;
        vectors++; if (grant_o !== 2'b00) begin errors++; $display("FAIL b2b_idle_gap got %b want 00", grant_o); end
        @(negedge clk_i); s_ack_i = 1; s_data_i = 32'h2222_0000; #1;
        vectors++; if (grant_o !== 2'b10 || s_addr_o !== 32'h8000_0200) begin errors++; $display("FAIL b2b_second got %b %h want 10 80000200", grant_o, s_addr_o); end
        vectors++; if (m1_ack_o !== 1'b1 || m1_data_o !== 32'h2222_0000 || m0_ack_o !== 1'b0 || m0_data_o !== 32'h0) begin errors++; $display("FAIL b2b_ack1 got %b %h %b %h", m1_ack_o, m1_data_o, m0_ack_o, m0_data_o); end
        @(negedge clk_i); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        @(negedge clk_i); #1;
        vectors++; if (grant_o !== 2'b00) begin errors++; $display("FAIL b2b_release1 got %b want 00", grant_o); end
        m0_request(1'b0, 32'h8000_0100, 3'b000); m1_request(1'b0, 32'h8000_0200, 3'b000);
        @(negedge clk_i); #1;
        vectors++; if (grant_o !== 2'b01) begin errors++; $display("FAIL b2b_alternate got %b want 01", grant_o); end
        @(negedge clk_i); clear_inputs();
        @(negedge clk_i);
    endtask

    task automatic test_amo_lock();
        @(negedge clk_i); m1_request(1'b0, 32'h8000_0010, 3'b101);
        @(negedge clk_i); s_ack_i = 1; s_data_i = 32'h0000_0042; #1;
        vectors++; if (grant_o !== 2'b10 || s_addr_tag_o !== 3'b101) begin errors++; $display("FAIL amo_lock_grant got %b %b want 10 101", grant_o, s_addr_tag_o); end
        vectors++; if (m1_ack_o !== 1'b1) begin errors++; $display("FAIL amo_lock_ack got %b want 1", m1_ack_o); end
        @(negedge clk_i); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m0_request(1'b0, 32'h8000_0020, 3'b000);
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (grant_o !== 2'b10 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL amo_held_%0d got %b %b want 10 0", i, grant_o, s_cyc_o); end
            @(negedge clk_i);
        end
        m1_request(1'b1, 32'h8000_0010, 3'b100); s_ack_i = 1; #1;
        vectors++; if (grant_o !== 2'b10 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin errors++; $display("FAIL amo_unlock got %b %b %b want 10 1 0", grant_o, m1_ack_o, m0_ack_o); end
        vectors++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL amo_no_timeout got %b want 0", timeout_o); end
        @(negedge clk_i); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; #1;
        vectors++; if (grant_o !== 2'b10) begin errors++; $display("FAIL amo_release_edge got %b want 10", grant_o); end
        @(negedge clk_i); #1;
        vectors++; if (grant_o !== 2'b00) begin errors++; $display("FAIL amo_idle got %b want 00", grant_o); end
        @(negedge clk_i); #1;
        vectors++; if (grant_o !== 2'b01 || s_addr_o !== 32'h8000_0020) begin errors++; $display("FAIL amo_m0_after got %b %h want 01 80000020", grant_o, s_addr_o); end
        @(negedge clk_i); clear_inputs();
        @(negedge clk_i);
    endtask

    task automatic test_amo_hold_expiry();
        @(negedge clk_i); m1_request(1'b0, 32'h8000_0010, 3'b101);
        @(negedge clk_i); s_ack_i = 1; #1;
        vectors++; if (grant_o !== 2'b10) begin errors++; $display("FAIL hold_grant got %b want 10", grant_o); end
        @(negedge clk_i); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            vectors++; if (grant_o !== 2'b10 || timeout_o !== 1'b0) begin errors++; $display("FAIL hold_idle_%0d got %b %b want 10 0", i, grant_o, timeout_o); end
            @(negedge clk_i);
        end
        #1;
        vectors++; if (grant_o !== 2'b00 || timeout_o !== 1'b1) begin errors++; $display("FAIL hold_expire got %b %b want 00 1", grant_o, timeout_o); end
        @(negedge clk_i); #1;
        vectors++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL hold_pulse_width got %b want 0", timeout_o); end
    endtask

    task automatic test_watchdog();
        @(negedge clk_i); m0_request(1'b0, 32'h8000_0030, 3'b000);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i); #1;
            vectors++; if (grant_o !== 2'b01 || m0_err_o !== 1'b0) begin errors++; $display("FAIL wd_stall_%0d got %b %b want 01 0", k, grant_o, m0_err_o); end
        end
        @(negedge clk_i); s_ack_i = 1; #1;
        vectors++; if (m0_err_o !== 1'b1 || timeout_o !== 1'b1) begin errors++; $display("FAIL wd_abort got err %b to %b want 1 1", m0_err_o, timeout_o); end
        vectors++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 2'b00) begin errors++; $display("FAIL wd_abort_bus got %b %b %b want 0 0 00", s_cyc_o, s_stb_o, grant_o); end
        vectors++; if (m0_ack_o !== 1'b0 || m1_err_o !== 1'b0) begin errors++; $display("FAIL wd_abort_ack_discard got %b %b want 0 0", m0_ack_o, m1_err_o); end
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        @(negedge clk_i); #1;
        vectors++; if (m0_err_o !== 1'b0 || timeout_o !== 1'b0 || grant_o !== 2'b00) begin errors++; $display("FAIL wd_after got %b %b %b want 0 0 00", m0_err_o, timeout_o, grant_o); end
    endtask

    task automatic test_ack_at_expiry();
        @(negedge clk_i); m0_request(1'b0, 32'h8000_0040, 3'b000);
        repeat (7) @(negedge clk_i);
        @(negedge clk_i); s_ack_i = 1; s_data_i = 32'h5A5A_5A5A; #1;
        vectors++; if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b0 || m0_data_o !== 32'h5A5A_5A5A) begin errors++; $display("FAIL race_ack got %b %b %h want 1 0 5a5a5a5a", m0_ack_o, m0_err_o, m0_data_o); end
        @(negedge clk_i); s_ack_i = 0; s_data_i = '0; m0_cyc_i = 0; m0_stb_i = 0; #1;
        vectors++; if (timeout_o !== 1'b0 || grant_o !== 2'b01) begin errors++; $display("FAIL race_no_abort got %b %b want 0 01", timeout_o, grant_o); end
        @(negedge clk_i); #1;
        vectors++; if (grant_o !== 2'b00 || timeout_o !== 1'b0) begin errors++; $display("FAIL race_release got %b %b want 00 0", grant_o, timeout_o); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i); m1_request(1'b1, 32'h8000_0050, 3'b000);
        @(negedge clk_i); #1;
        vectors++; if (grant_o !== 2'b10 || s_cyc_o !== 1'b1) begin errors++; $display("FAIL mid_owner got %b %b want 10 1", grant_o, s_cyc_o); end
        s_ack_i = 1; s_data_i = 32'hFFFF_FFFF;
        #1 rst_i = 0;
        #1;
        vectors++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("FAIL mid_async got %b %b %b want 00 0 0", grant_o, s_cyc_o, s_stb_o); end
        vectors++; if (m1_ack_o !== 1'b0 || m1_data_o !== 32'h0 || s_addr_o !== 32'h0) begin errors++; $display("FAIL mid_async_data got %b %h %h want 0 0 0", m1_ack_o, m1_data_o, s_addr_o); end
        @(negedge clk_i); rst_i = 1; clear_inputs();
        m0_request(1'b0, 32'h8000_0060, 3'b000); m1_request(1'b0, 32'h8000_0070, 3'b000);
        @(negedge clk_i); #1;
        vectors++; if (grant_o !== 2'b01) begin errors++; $display("FAIL mid_regrant got %b want 01", grant_o); end
        @(negedge clk_i); clear_inputs();
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_amo_lock();
        test_amo_hold_expiry();
        test_watchdog();
        test_ack_at_expiry();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Two-master Wishbone arbiter in front of io_bus; shares the single IO slave port between M0 (CPU data port) and M1 (debug/DMA master).
- Round-robin grant with bus hold for the whole cyc_i burst, and for AMO lock…unlock sequences across cycles.
- Watchdog aborts stalled transactions with err.
- Passes addr_tag/data_tag through unchanged, so io_bus reservation logic stays authoritative.

Parameters:
TIMEOUT_CYCLES, 256, slave cycles without ack/err before abort; must be ≥2.
AMO_HOLD_MAX, 64, idle cycles a granted master may hold an AMO lock before forced release.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-low reset
m0_stb_i, m0_cyc_i, m0_we_i  in  1 each  M0 Wishbone strobe/cycle/write
m0_addr_i  in  32  M0 address
m0_addr_tag_i  in  3  M0 tag {mode[1:0], lock/unlock}
m0_data_i  in  32  M0 write data
m0_sel_i  in  4  M0 byte select
m0_ack_o, m0_err_o, m0_data_tag_o  out  1 each  M0 responses
m0_data_o  out  32  M0 read data
m1_*  —  identical set for M1
s_stb_o, s_cyc_o, s_we_o  out  1 each  to io_bus
s_addr_o  out  32  to io_bus
s_addr_tag_o  out  3  to io_bus
s_data_o  out  32  to io_bus
s_sel_o  out  4  to io_bus
s_ack_i, s_err_i, s_data_tag_i  in  1 each  from io_bus
s_data_i  in  32  from io_bus
grant_o  out  2  one-hot current owner, for debug/perf counters
timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant=M1 (so M0 wins first), counters 0. Reset takes effect asynchronously; release is synchronous to clk_i.
- States:
  - IDLE: no owner, s_cyc_o=s_stb_o=0.
  - OWN0 / OWN1: master muxed to the slave.
  - ABORT: one cycle.
- IDLE→OWNx when mx_cyc_i&mx_stb_i, registered, 1-cycle grant latency.
  - Both request: the master ≠ last_grant wins.
- OWNx mux:
  - s_* = mx_* combinationally; s_stb_o gated by mx_stb_i.
  - Responses route only to owner: mx_ack_o=s_ack_i, mx_err_o=s_err_i, mx_data_o=s_data_i, mx_data_tag_o=s_data_tag_i.
  - Non-owner ack/err/data_tag = 0, data = 0.
- Release OWNx→IDLE when mx_cyc_i falls and amo_held=0; last_grant←x. No back-to-back grant to the other master in the same cycle: one IDLE cycle minimum.
- AMO hold:
  - amo_held set on acked transfer with tag mode AMO, bit0=LOCK, !we.
  - amo_held cleared on acked AMO UNLOCK write.
  - While amo_held, ownership persists even if mx_cyc_i drops.
  - hold_cnt counts idle cycles (cyc low) and resets on any owner strobe. At AMO_HOLD_MAX: force release, clear amo_held, pulse timeout_o.
- Watchdog:
  - wd_cnt increments each cycle s_stb_o=1 with no s_ack_i/s_err_i; cleared on ack/err or stb low.
  - wd_cnt==TIMEOUT_CYCLES-1 → ABORT: drop s_cyc_o/s_stb_o, assert mx_err_o for exactly one cycle, pulse timeout_o, clear amo_held, then IDLE.
  - An s_ack_i arriving in ABORT is discarded.
- Simultaneous ack and watchdog expiry in the same cycle: ack wins, no abort.
- Owner drops cyc mid-strobe without ack: slave signals drop the same cycle (combinational pass-through), release next edge.
- LR/SC tags are passed through unheld; io_bus handles reservation failure via data_tag.
- Counters saturate; they never wrap.

Decomposition:
- Shared package io_arb_pkg:
  - state enum (IDLE, OWN0, OWN1, ABORT)
  - master index typedef
  - helper function is_amo_lock(tag, we) / is_amo_unlock(tag, we), built from existing ADDR_TAG_* defines
- Sub-module io_arb_watchdog: counter + expiry compare, parameterised by TIMEOUT_CYCLES, reused for the AMO hold counter with AMO_HOLD_MAX.

Test Plan:
1. M0 single read 0x8000_0004, slave acks after 3 cycles → grant_o=01 next cycle, m0_ack_o 1 cycle with s_data_i=0xDEAD_BEEF, m1 outputs 0, IDLE after cyc drop.
2. M0 and M1 request same cycle from reset → M0 granted first; M1 granted after M0 release plus one IDLE cycle; next simultaneous request goes to M0 again (alternation).
3. M1 AMO LOCK read @0x8000_0010, drop cyc 5 cycles, M0 requests meanwhile → M0 blocked until M1 UNLOCK write acked, then M0 granted.
4. Slave never acks, TIMEOUT_CYCLES=8 → abort at 8th stalled cycle: m0_err_o=1 for 1 cycle, timeout_o pulse, s_cyc_o=0, state IDLE.
5. s_ack_i coincident with watchdog expiry → m0_ack_o=1, m0_err_o=0, timeout_o=0.
6. rst_i asserted low mid-transfer with M1 owning → all outputs 0 immediately (before next edge); after release, simultaneous request grants M0.
